// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite animation controller.
package sprite_pkg;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DIR_W   = 2;
    localparam int unsigned FRAME_W = 2;

    typedef logic [DIR_W-1:0] dir_t;

    typedef enum logic [1:0] {
        PAC_OPEN,
        PAC_HALF_C,
        PAC_CLOSED,
        PAC_HALF_O
    } pac_anim_e;

    // Directions captured together at a frame boundary
    typedef struct packed {
        dir_t pac;
        dir_t ghost1;
        dir_t ghost2;
    } dir_set_t;

    localparam logic [FRAME_W-1:0] PAC_FRAME_OPEN   = 2'd0;
    localparam logic [FRAME_W-1:0] PAC_FRAME_HALF   = 2'd1;
    localparam logic [FRAME_W-1:0] PAC_FRAME_CLOSED = 2'd2;

    function automatic logic [FRAME_W-1:0] pac_frame(input pac_anim_e s);
        logic [FRAME_W-1:0] f;
        f = PAC_FRAME_OPEN;
        case (s)
            PAC_OPEN:   f = PAC_FRAME_OPEN;
            PAC_HALF_C: f = PAC_FRAME_HALF;
            PAC_CLOSED: f = PAC_FRAME_CLOSED;
            PAC_HALF_O: f = PAC_FRAME_HALF;
            default:    f = PAC_FRAME_OPEN;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/anim_div.sv
// Modulo-DIV frame divider: counts enabled ticks and flags the wrapping tick.
module anim_div
    import sprite_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic wrap_c
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign wrap_c = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Frame-synchronous sprite glyph sequencer for the font ROM.
// GHOST_ANIM_EN: build the ghost skirt divider; otherwise ghost_phase is tied to 0.
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int unsigned PAC_DIV   = 4,
    parameter int unsigned GHOST_DIV = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       moving,
    input  logic       freeze,
    input  logic [1:0] pac_dir_in,
    input  logic [1:0] ghost1_dir_in,
    input  logic [1:0] ghost2_dir_in,
    output logic [1:0] pac_move,
    output logic       ghost_phase,
    output logic [1:0] pac_dir,
    output logic [1:0] ghost1_dir,
    output logic [1:0] ghost2_dir,
    output logic       frame_tick
);

    if (PAC_DIV == 0 || PAC_DIV > 15 || GHOST_DIV == 0 || GHOST_DIV > 15) begin : g_bad_div
        $error("sprite_anim_ctrl: PAC_DIV and GHOST_DIV must be in 1..15");
    end

    logic      frame_q;
    logic      armed;
    logic      frame_edge_c;
    logic      adv_c;
    logic      pac_step_c;
    pac_anim_e pac_state;
    pac_anim_e pac_state_nxt;
    dir_set_t  dirs;

    // armed stays low for one clock so a frame_clk already high at release is not an edge
    assign frame_edge_c = armed && frame_clk && !frame_q;
    assign adv_c        = frame_edge_c && !freeze;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_q    <= 1'b0;
            armed      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_q    <= frame_clk;
            armed      <= 1'b1;
            frame_tick <= frame_edge_c;
        end
    end

    anim_div #(.DIV(PAC_DIV)) u_pac_div (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .en     (adv_c && moving),
        .wrap_c (pac_step_c)
    );

    // Mouth sequence: open, half, closed, half, open
    always_comb begin
        pac_state_nxt = pac_state;
        if (pac_step_c) begin
            case (pac_state)
                PAC_OPEN:   pac_state_nxt = PAC_HALF_C;
                PAC_HALF_C: pac_state_nxt = PAC_CLOSED;
                PAC_CLOSED: pac_state_nxt = PAC_HALF_O;
                PAC_HALF_O: pac_state_nxt = PAC_OPEN;
                default:    pac_state_nxt = PAC_OPEN;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pac_state <= PAC_OPEN;
            pac_move  <= PAC_FRAME_OPEN;
        end else begin
            pac_state <= pac_state_nxt;
            pac_move  <= pac_frame(pac_state_nxt);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dirs <= '0;
        end else if (adv_c) begin
            dirs <= '{pac: pac_dir_in, ghost1: ghost1_dir_in, ghost2: ghost2_dir_in};
        end
    end

    assign pac_dir    = dirs.pac;
    assign ghost1_dir = dirs.ghost1;
    assign ghost2_dir = dirs.ghost2;

`ifdef GHOST_ANIM_EN
    logic ghost_wrap_c;

    anim_div #(.DIV(GHOST_DIV)) u_ghost_div (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .en     (adv_c),
        .wrap_c (ghost_wrap_c)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ghost_phase <= 1'b0;
        end else if (ghost_wrap_c) begin
            ghost_phase <= ~ghost_phase;
        end
    end
`else
    assign ghost_phase = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed self-checking bench for sprite_anim_ctrl (default PAC_DIV=4, GHOST_DIV=8).
module tb_sprite_anim_ctrl;

    localparam int unsigned GD = 8;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       frame_clk = 1'b0;
    logic       moving = 1'b0;
    logic       freeze = 1'b0;
    logic [1:0] pac_dir_in = 2'd0;
    logic [1:0] ghost1_dir_in = 2'd0;
    logic [1:0] ghost2_dir_in = 2'd0;
    logic [1:0] pac_move;
    logic       ghost_phase;
    logic [1:0] pac_dir;
    logic [1:0] ghost1_dir;
    logic [1:0] ghost2_dir;
    logic       frame_tick;

    int tests = 0;
    int fails = 0;
    int tick_cnt = 0;
    int ghost_frames = 0;

    sprite_anim_ctrl dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_clk     (frame_clk),
        .moving        (moving),
        .freeze        (freeze),
        .pac_dir_in    (pac_dir_in),
        .ghost1_dir_in (ghost1_dir_in),
        .ghost2_dir_in (ghost2_dir_in),
        .pac_move      (pac_move),
        .ghost_phase   (ghost_phase),
        .pac_dir       (pac_dir),
        .ghost1_dir    (ghost1_dir),
        .ghost2_dir    (ghost2_dir),
        .frame_tick    (frame_tick)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (frame_tick === 1'b1) tick_cnt++;
    end

    function automatic logic ghost_exp(input int n);
`ifdef GHOST_ANIM_EN
        return ((n / GD) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    // One clean frame_clk pulse; outputs settle before the task returns
    task automatic pulse_frame();
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
        if (!freeze) ghost_frames++;
    endtask

    task automatic test_reset();
        #1 Reset_n = 1'b0;
        #1;
        tests++;
        if (pac_move !== 2'd0 || ghost_phase !== 1'b0 || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: pac_move=%0d ghost_phase=%0b frame_tick=%0b, required 0/0/0",
                     pac_move, ghost_phase, frame_tick);
        end
        tests++;
        if (pac_dir !== 2'd0 || ghost1_dir !== 2'd0 || ghost2_dir !== 2'd0) begin
            fails++;
            $display("FAIL reset_dirs: %0d/%0d/%0d, required 0/0/0", pac_dir, ghost1_dir, ghost2_dir);
        end
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        ghost_frames = 0;
    endtask

    task automatic test_pac_cycle();
        logic [1:0] exp_pac [0:16];
        int t0;
        exp_pac = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2,
                    2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
        t0 = tick_cnt;
        moving = 1'b1;
        for (int f = 0; f < 17; f++) begin
            pulse_frame();
            tests++;
            if (pac_move !== exp_pac[f]) begin
                fails++;
                $display("FAIL pac_cycle frame %0d: pac_move=%0d required %0d", f + 1, pac_move, exp_pac[f]);
            end
            tests++;
            if (ghost_phase !== ghost_exp(ghost_frames)) begin
                fails++;
                $display("FAIL ghost_cycle frame %0d: ghost_phase=%0b required %0b",
                         f + 1, ghost_phase, ghost_exp(ghost_frames));
            end
        end
        tests++;
        if (tick_cnt - t0 !== 17) begin
            fails++;
            $display("FAIL tick_count_17: got %0d required 17", tick_cnt - t0);
        end
    endtask

    task automatic test_hold();
        moving = 1'b1;
        repeat (7) pulse_frame();
        tests++;
        if (pac_move !== 2'd2) begin
            fails++;
            $display("FAIL hold_reach_closed: pac_move=%0d required 2", pac_move);
        end
        moving = 1'b0;
        for (int f = 0; f < 10; f++) begin
            pulse_frame();
            tests++;
            if (pac_move !== 2'd2 || ghost_phase !== ghost_exp(ghost_frames)) begin
                fails++;
                $display("FAIL hold_stopped frame %0d: pac_move=%0d ghost_phase=%0b required 2/%0b",
                         f, pac_move, ghost_phase, ghost_exp(ghost_frames));
            end
        end
        moving = 1'b1;
        repeat (3) pulse_frame();
        tests++;
        if (pac_move !== 2'd2) begin
            fails++;
            $display("FAIL hold_resume_3: pac_move=%0d required 2", pac_move);
        end
        pulse_frame();
        tests++;
        if (pac_move !== 2'd1) begin
            fails++;
            $display("FAIL hold_resume_4: pac_move=%0d required 1", pac_move);
        end
    endtask

    task automatic test_freeze();
        int  t0;
        logic g0;
        moving        = 1'b1;
        pac_dir_in    = 2'd2;
        ghost1_dir_in = 2'd1;
        ghost2_dir_in = 2'd3;
        pulse_frame();
        tests++;
        if (pac_dir !== 2'd2 || ghost1_dir !== 2'd1 || ghost2_dir !== 2'd3 || pac_move !== 2'd1) begin
            fails++;
            $display("FAIL freeze_setup: dirs %0d/%0d/%0d pac_move=%0d required 2/1/3 and 1",
                     pac_dir, ghost1_dir, ghost2_dir, pac_move);
        end
        g0 = ghost_exp(ghost_frames);
        freeze        = 1'b1;
        pac_dir_in    = 2'd0;
        ghost1_dir_in = 2'd2;
        ghost2_dir_in = 2'd0;
        t0 = tick_cnt;
        for (int f = 0; f < 20; f++) begin
            pulse_frame();
            tests++;
            if (pac_move !== 2'd1 || ghost_phase !== g0 ||
                pac_dir !== 2'd2 || ghost1_dir !== 2'd1 || ghost2_dir !== 2'd3) begin
                fails++;
                $display("FAIL freeze_hold frame %0d: pac_move=%0d ghost=%0b dirs %0d/%0d/%0d required 1/%0b 2/1/3",
                         f, pac_move, ghost_phase, pac_dir, ghost1_dir, ghost2_dir, g0);
            end
        end
        tests++;
        if (tick_cnt - t0 !== 20) begin
            fails++;
            $display("FAIL freeze_ticks: got %0d required 20", tick_cnt - t0);
        end
        freeze = 1'b0;
    endtask

    task automatic test_held_high();
        int t0;
        moving = 1'b0;
        t0 = tick_cnt;
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (100) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        ghost_frames++;
        tests++;
        if (tick_cnt - t0 !== 1) begin
            fails++;
            $display("FAIL held_high_ticks: got %0d required 1", tick_cnt - t0);
        end
        tests++;
        if (pac_dir !== 2'd0 || ghost1_dir !== 2'd2 || ghost2_dir !== 2'd0) begin
            fails++;
            $display("FAIL held_high_dirs: %0d/%0d/%0d required 0/2/0", pac_dir, ghost1_dir, ghost2_dir);
        end
    endtask

    task automatic test_dir_midframe();
        moving = 1'b0;
        repeat (3) @(negedge Clk);
        pac_dir_in = 2'd3;
        repeat (4) @(negedge Clk);
        tests++;
        if (pac_dir !== 2'd0) begin
            fails++;
            $display("FAIL dir_midframe_hold: pac_dir=%0d required 0", pac_dir);
        end
        frame_clk = 1'b1;
        @(negedge Clk);
        tests++;
        if (frame_tick !== 1'b1 || pac_dir !== 2'd3) begin
            fails++;
            $display("FAIL dir_on_tick: frame_tick=%0b pac_dir=%0d required 1/3", frame_tick, pac_dir);
        end
        @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
        ghost_frames++;
    endtask

    task automatic test_reset_release_high();
        int t0;
        @(negedge Clk);
        Reset_n   = 1'b0;
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        t0 = tick_cnt;
        Reset_n = 1'b1;
        ghost_frames = 0;
        repeat (6) @(negedge Clk);
        tests++;
        if (tick_cnt - t0 !== 0) begin
            fails++;
            $display("FAIL release_high_no_tick: got %0d ticks required 0", tick_cnt - t0);
        end
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        pulse_frame();
        tests++;
        if (tick_cnt - t0 !== 1) begin
            fails++;
            $display("FAIL release_fresh_rise: got %0d ticks required 1", tick_cnt - t0);
        end
    endtask

    task automatic test_reset_mid();
        moving = 1'b1;
        repeat (8) pulse_frame();
        tests++;
        if (pac_move !== 2'd2 || ghost_phase !== ghost_exp(ghost_frames)) begin
            fails++;
            $display("FAIL reset_mid_pre: pac_move=%0d ghost_phase=%0b required 2/%0b",
                     pac_move, ghost_phase, ghost_exp(ghost_frames));
        end
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        tests++;
        if (pac_move !== 2'd0 || ghost_phase !== 1'b0 || pac_dir !== 2'd0) begin
            fails++;
            $display("FAIL reset_mid_async: pac_move=%0d ghost_phase=%0b pac_dir=%0d required 0/0/0",
                     pac_move, ghost_phase, pac_dir);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        ghost_frames = 0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_ghost_50();
        moving = 1'b1;
        for (int f = 0; f < 50; f++) begin
            pulse_frame();
            tests++;
            if (ghost_phase !== ghost_exp(ghost_frames)) begin
                fails++;
                $display("FAIL ghost_50 frame %0d: ghost_phase=%0b required %0b",
                         f + 1, ghost_phase, ghost_exp(ghost_frames));
            end
        end
    endtask

    initial begin
        test_reset();
        test_pac_cycle();
        test_hold();
        test_freeze();
        test_held_high();
        test_dir_midframe();
        test_reset_release_high();
        test_reset_mid();
        test_ghost_50();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
